icache_loader: RTL and testbench

Boot-time filler for the ICache write port. Accepts a little-endian byte stream (length header then payload) over a valid/ready handshake and assembles 16-bit Thumb halfwords. Writes each halfword into consecutive ICache cells starting at index 0, and holds instruction fetch (`not_enable`) until the image is complete. Sits between the host byte link (UART receiver) and `ICache`'s `write_enable` / `write_instruction_index` / `write_instruction` inputs.

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_loader.sv | 120 ++++++++++++
 tb/tb_icache_loader.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared ICache header: cell count, index/instruction widths and loader FSM encodings.
// The ICache and its boot loader both size themselves from these defaults.
package icache_pkg;

   localparam int unsigned IcacheDepth      = 256;
   localparam int unsigned IcacheIndexWidth = 32;
   localparam int unsigned InstrWidth       = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StDataLo,
      StDataHi,
      StDone,
      StError
   } loader_state_e;

endpackage

// File: rtl/icache_loader.sv
// Boot-time ICache filler: takes a length-prefixed little-endian byte stream and writes
// consecutive 16-bit halfwords from index 0, holding CPU fetch until the image is complete.
module icache_loader
   import icache_pkg::*;
#(
   parameter int unsigned DEPTH       = IcacheDepth,
   parameter int unsigned INDEX_WIDTH = IcacheIndexWidth
) (
   input  logic                   clk,
   input  logic                   not_reset,
   input  logic                   start,
   input  logic                   byte_valid,
   input  logic [7:0]             byte_data,
   output logic                   byte_ready,
   output logic                   write_enable,
   output logic [INDEX_WIDTH-1:0] write_instruction_index,
   output logic [InstrWidth-1:0]  write_instruction,
   output logic                   cpu_hold,
   output logic                   done,
   output logic                   error
);

   // One spare bit so a count equal to DEPTH is representable.
   localparam int unsigned CntWidth = $clog2(DEPTH) + 1;

   loader_state_e         state_q;
   logic [7:0]            len_lo_q;
   logic [7:0]            data_lo_q;
   logic [15:0]           len_q;
   logic [CntWidth-1:0]   cnt_q;

   logic                  accept;
   logic [15:0]           len_rx;
   logic                  last_hw;

   assign accept  = byte_valid && byte_ready;
   assign len_rx  = {byte_data, len_lo_q};
   assign last_hw = (32'(cnt_q) + 32'd1) == 32'(len_q);

   always_ff @(posedge clk or negedge not_reset) begin
      if (!not_reset) begin
         state_q                 <= StIdle;
         len_lo_q                <= '0;
         data_lo_q               <= '0;
         len_q                   <= '0;
         cnt_q                   <= '0;
         byte_ready              <= 1'b0;
         write_enable            <= 1'b0;
         write_instruction_index <= '0;
         write_instruction       <= '0;
         cpu_hold                <= 1'b1;
         done                    <= 1'b0;
         error                   <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         done         <= 1'b0;
         case (state_q)
            StIdle, StDone, StError: begin
               if (start) begin
                  state_q    <= StLenLo;
                  byte_ready <= 1'b1;
                  error      <= 1'b0;
                  cpu_hold   <= 1'b1;
                  cnt_q      <= '0;
               end
            end
            StLenLo: begin
               if (accept) begin
                  len_lo_q <= byte_data;
                  state_q  <= StLenHi;
               end
            end
            StLenHi: begin
               if (accept) begin
                  len_q <= len_rx;
                  if (32'(len_rx) > DEPTH) begin
                     state_q    <= StError;
                     byte_ready <= 1'b0;
                     error      <= 1'b1;
                  end else if (len_rx == 16'd0) begin
                     state_q    <= StDone;
                     byte_ready <= 1'b0;
                     done       <= 1'b1;
                     cpu_hold   <= 1'b0;
                  end else begin
                     state_q <= StDataLo;
                  end
               end
            end
            StDataLo: begin
               if (accept) begin
                  data_lo_q <= byte_data;
                  state_q   <= StDataHi;
               end
            end
            StDataHi: begin
               if (accept) begin
                  write_enable            <= 1'b1;
                  write_instruction_index <= INDEX_WIDTH'(cnt_q);
                  write_instruction       <= {byte_data, data_lo_q};
                  cnt_q                   <= cnt_q + CntWidth'(1);
                  if (last_hw) begin
                     state_q    <= StDone;
                     byte_ready <= 1'b0;
                     done       <= 1'b1;
                     cpu_hold   <= 1'b0;
                  end else begin
                     state_q <= StDataLo;
                  end
               end
            end
            default: begin
               state_q    <= StIdle;
               byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_loader.sv
// Scoreboard bench for icache_loader: stimulus pushes expected write/done events,
// a negedge monitor pops and compares them and mirrors writes into a small ICache model.
module tb_icache_loader;

   logic        clk;
   logic        not_reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        write_enable;
   logic [31:0] write_instruction_index;
   logic [15:0] write_instruction;
   logic        cpu_hold;
   logic        done;
   logic        error;

   typedef struct {
      logic        we;
      logic [31:0] idx;
      logic [15:0] data;
      logic        done;
   } ev_t;

   ev_t         exp_q[$];
   logic [15:0] mem [0:255];
   int          checks;
   int          errors;
   int          cyc;
   int          last_we_cyc;
   logic        spacing_on;
   logic        we_prev;

   icache_loader #(
      .DEPTH      (256),
      .INDEX_WIDTH(32)
   ) dut (
      .clk                    (clk),
      .not_reset              (not_reset),
      .start                  (start),
      .byte_valid             (byte_valid),
      .byte_data              (byte_data),
      .byte_ready             (byte_ready),
      .write_enable           (write_enable),
      .write_instruction_index(write_instruction_index),
      .write_instruction      (write_instruction),
      .cpu_hold               (cpu_hold),
      .done                   (done),
      .error                  (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_write(input int idx, input logic [15:0] data, input logic last);
      ev_t e;
      e.we   = 1'b1;
      e.idx  = 32'(idx);
      e.data = data;
      e.done = last;
      exp_q.push_back(e);
   endtask

   task automatic push_done_only();
      ev_t e;
      e.we   = 1'b0;
      e.idx  = '0;
      e.data = '0;
      e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every write/done against the head of the scoreboard.
   always @(negedge clk) begin
      ev_t e;
      cyc++;
      if (not_reset && (write_enable || done)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: we=%0b done=%0b idx=%0h data=%0h, none expected",
                     write_enable, done, write_instruction_index, write_instruction);
         end else begin
            e = exp_q.pop_front();
            chk("ev_write_enable", 32'(write_enable), 32'(e.we));
            chk("ev_done", 32'(done), 32'(e.done));
            chk("ev_cpu_hold", 32'(cpu_hold), 32'(!e.done));
            if (e.we) begin
               chk("ev_index", write_instruction_index, e.idx);
               chk("ev_data", 32'(write_instruction), 32'(e.data));
            end
         end
         if (write_enable) begin
            mem[write_instruction_index[7:0]] = write_instruction;
            chk("we_single_cycle", 32'(we_prev), 32'd0);
            if (spacing_on && last_we_cyc >= 0) chk("write_spacing", 32'(cyc - last_we_cyc), 32'd2);
            last_we_cyc = cyc;
         end
      end
      we_prev = not_reset && write_enable;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles; returns #1 after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic rdy;
      logic ok;
      byte_valid = 1'b0;
      repeat (gap) tick();
      byte_valid = 1'b1;
      byte_data  = b;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         rdy = byte_ready;
         tick();
         if (rdy) ok = 1'b1;
      end
      byte_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL byte_accept_timeout: byte %0h not accepted, required within 100 cycles", b);
      end
   endtask

   task automatic send_image(input logic [7:0] bytes[8], input int gaps[8]);
      for (int i = 0; i < 8; i++) send_byte(bytes[i], gaps[i]);
   endtask

   initial begin
      logic [7:0] img[8];
      int         g0[8];
      int         gr[8];
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required to finish");
      $fatal(1, "timeout");
      img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      g0  = '{0, 0, 0, 0, 0, 0, 0, 0};
      gr  = g0;
   end

   initial begin
      logic [7:0] img[8];
      int         g0[8];
      int         gr[8];
      img = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
      g0  = '{0, 0, 0, 0, 0, 0, 0, 0};
      gr  = '{1, 3, 2, 1, 2, 3, 1, 2};
      checks      = 0;
      errors      = 0;
      cyc         = 0;
      last_we_cyc = -1;
      spacing_on  = 1'b0;
      we_prev     = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      not_reset  = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) tick();

      // Reset values
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_write_enable", 32'(write_enable), 32'd0);
      chk("rst_index", write_instruction_index, 32'd0);
      chk("rst_data", 32'(write_instruction), 32'd0);
      chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      not_reset = 1'b1;
      repeat (2) tick();

      // 1: back-to-back three-halfword image
      push_write(0, 16'h1234, 1'b0);
      push_write(1, 16'h5678, 1'b0);
      push_write(2, 16'h9ABC, 1'b1);
      pulse_start();
      chk("t1_ready_after_start", 32'(byte_ready), 32'd1);
      spacing_on  = 1'b1;
      last_we_cyc = -1;
      send_image(img, g0);
      chk("t1_done_level", 32'(done), 32'd1);
      repeat (3) tick();
      spacing_on = 1'b0;
      chk("t1_cpu_hold_after", 32'(cpu_hold), 32'd0);
      chk("t1_ready_in_done", 32'(byte_ready), 32'd0);
      chk("t1_done_one_cycle", 32'(done), 32'd0);
      chk("t1_mem0", 32'(mem[0]), 32'h1234);
      chk("t1_mem1", 32'(mem[1]), 32'h5678);
      chk("t1_mem2", 32'(mem[2]), 32'h9ABC);
      chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

      // 2: same image with idle gaps
      for (int i = 0; i < 3; i++) mem[i] = 16'h0000;
      push_write(0, 16'h1234, 1'b0);
      push_write(1, 16'h5678, 1'b0);
      push_write(2, 16'h9ABC, 1'b1);
      pulse_start();
      chk("t2_cpu_hold_during", 32'(cpu_hold), 32'd1);
      send_image(img, gr);
      repeat (3) tick();
      chk("t2_mem0", 32'(mem[0]), 32'h1234);
      chk("t2_mem2", 32'(mem[2]), 32'h9ABC);
      chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

      // 3: zero-length image
      push_done_only();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("t3_done", 32'(done), 32'd1);
      tick();
      chk("t3_cpu_hold", 32'(cpu_hold), 32'd0);
      chk("t3_done_one_cycle", 32'(done), 32'd0);
      chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // 4: length 257 exceeds DEPTH, then recover
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      chk("t4_error", 32'(error), 32'd1);
      chk("t4_ready", 32'(byte_ready), 32'd0);
      chk("t4_cpu_hold", 32'(cpu_hold), 32'd1);
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      repeat (5) tick();
      byte_valid = 1'b0;
      chk("t4_error_sticky", 32'(error), 32'd1);
      pulse_start();
      chk("t4_error_cleared", 32'(error), 32'd0);
      push_write(0, 16'hBEEF, 1'b1);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hEF, 0);
      send_byte(8'hBE, 0);
      tick();
      chk("t4_cpu_hold_after", 32'(cpu_hold), 32'd0);
      chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

      // 5: start mid-payload is ignored
      push_write(0, 16'h0201, 1'b0);
      push_write(1, 16'h0403, 1'b1);
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      start = 1'b1;
      send_byte(8'h03, 0);
      start = 1'b0;
      send_byte(8'h04, 1);
      tick();
      chk("t5_cpu_hold_after", 32'(cpu_hold), 32'd0);
      chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

      // 6: reset after the first halfword, then reload from index 0
      push_write(0, 16'h2211, 1'b0);
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      @(negedge clk);
      #1;
      not_reset = 1'b0;
      #1;
      chk("t6_byte_ready", 32'(byte_ready), 32'd0);
      chk("t6_write_enable", 32'(write_enable), 32'd0);
      chk("t6_index", write_instruction_index, 32'd0);
      chk("t6_data", 32'(write_instruction), 32'd0);
      chk("t6_cpu_hold", 32'(cpu_hold), 32'd1);
      chk("t6_done", 32'(done), 32'd0);
      chk("t6_error", 32'(error), 32'd0);
      repeat (2) tick();
      not_reset = 1'b1;
      tick();
      mem[0] = 16'h0000;
      push_write(0, 16'hABCD, 1'b1);
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hCD, 0);
      send_byte(8'hAB, 0);
      repeat (2) tick();
      chk("t6_mem0", 32'(mem[0]), 32'hABCD);
      chk("t6_cpu_hold_after", 32'(cpu_hold), 32'd0);
      chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
